// File: rtl/session_pkg.sv
// Shared definitions for the session-to-transport arbiter: command encoding,
// FSM state type and the default payload width.
package session_pkg;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_CTRL  = 2'b01;
    localparam logic [1:0] CMD_AUDIO = 2'b10;

    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the lowest requesting index at or
// after ptr, wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // Scan N positions starting at ptr; first request seen wins.
    always_comb begin
        logic found;
        int   pos;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = |req;
        found      = 1'b0;
        pos        = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && req[pos]) begin
                found           = 1'b1;
                gnt_onehot[pos] = 1'b1;
                gnt_idx         = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/transport_arbiter.sv
// Shares one transport link between NUM_SESS sessions. Each session owns one
// control slot and one audio slot; control has strict priority over audio and
// each class is served round-robin. One packet is issued per 2+HOLDOFF cycles.
module transport_arbiter
    import session_pkg::*;
#(
    parameter  int NUM_SESS = 4,
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int DROP_W   = 8,
    parameter  int HOLDOFF  = 1,
    localparam int SW       = $clog2(NUM_SESS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2*NUM_SESS-1:0]        in_cmd,
    input  logic [DATA_W*NUM_SESS-1:0]   in_data,
    input  logic                         transport_busy,
    output logic [1:0]                   out_cmd,
    output logic [DATA_W-1:0]            out_data,
    output logic [SW-1:0]                out_src,
    output logic [NUM_SESS-1:0]          sess_busy,
    output logic [DROP_W-1:0]            audio_drops
);

    localparam int             HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0]  HOLD_INIT = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    state_e                 state_q, state_d;
    logic [1:0]             out_cmd_q, out_cmd_d;
    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic [SW-1:0]          out_src_q, out_src_d;
    logic [NUM_SESS-1:0]    gnt_mask_q, gnt_mask_d;
    logic [SW-1:0]          ctrl_ptr_q, ctrl_ptr_d;
    logic [SW-1:0]          aud_ptr_q, aud_ptr_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [DROP_W-1:0]      drops_q, drops_d;

    logic [NUM_SESS-1:0]    ctrl_full_q, aud_full_q;
    logic [DATA_W-1:0]      ctrl_data_q [NUM_SESS];
    logic [DATA_W-1:0]      aud_data_q  [NUM_SESS];

    logic [NUM_SESS-1:0]    ctrl_wr, aud_wr, ctrl_accept, aud_ovf;
    logic [NUM_SESS-1:0]    ctrl_clr, aud_clr;

    logic [NUM_SESS-1:0]    ctrl_gnt, aud_gnt;
    logic [SW-1:0]          ctrl_idx, aud_idx;
    logic                   ctrl_any, aud_any;

    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] idx);
        return (idx == SW'(NUM_SESS - 1)) ? '0 : idx + SW'(1);
    endfunction

    // Per-session command decode. A control write is taken if the slot is
    // empty or is being cleared by the current grant (new write wins).
    // Reserved code 11 matches neither class and is ignored.
    for (genvar gi = 0; gi < NUM_SESS; gi++) begin : g_decode
        assign ctrl_wr[gi]     = (in_cmd[2*gi +: 2] == CMD_CTRL);
        assign aud_wr[gi]      = (in_cmd[2*gi +: 2] == CMD_AUDIO);
        assign ctrl_accept[gi] = ctrl_wr[gi] && (!ctrl_full_q[gi] || ctrl_clr[gi]);
        assign aud_ovf[gi]     = aud_wr[gi] && aud_full_q[gi] && !aud_clr[gi];
    end

    rr_arbiter #(.N(NUM_SESS)) u_ctrl_arb (
        .req        (ctrl_full_q),
        .ptr        (ctrl_ptr_q),
        .gnt_onehot (ctrl_gnt),
        .gnt_idx    (ctrl_idx),
        .any        (ctrl_any)
    );

    rr_arbiter #(.N(NUM_SESS)) u_aud_arb (
        .req        (aud_full_q),
        .ptr        (aud_ptr_q),
        .gnt_onehot (aud_gnt),
        .gnt_idx    (aud_idx),
        .any        (aud_any)
    );

    // Next-state, output load and slot-clear decisions.
    always_comb begin
        state_d    = state_q;
        out_cmd_d  = CMD_NONE;
        out_data_d = '0;
        out_src_d  = '0;
        gnt_mask_d = '0;
        ctrl_ptr_d = ctrl_ptr_q;
        aud_ptr_d  = aud_ptr_q;
        hold_cnt_d = hold_cnt_q;
        ctrl_clr   = '0;
        aud_clr    = '0;
        case (state_q)
            IDLE: begin
                if (!transport_busy && (ctrl_any || aud_any)) begin
                    state_d = SEND;
                    if (ctrl_any) begin
                        out_cmd_d  = CMD_CTRL;
                        out_data_d = ctrl_data_q[ctrl_idx];
                        out_src_d  = ctrl_idx;
                        gnt_mask_d = ctrl_gnt;
                    end else begin
                        out_cmd_d  = CMD_AUDIO;
                        out_data_d = aud_data_q[aud_idx];
                        out_src_d  = aud_idx;
                        gnt_mask_d = aud_gnt;
                    end
                end
            end
            SEND: begin
                if (out_cmd_q == CMD_CTRL) begin
                    ctrl_clr   = gnt_mask_q;
                    ctrl_ptr_d = wrap_inc(out_src_q);
                end else begin
                    aud_clr    = gnt_mask_q;
                    aud_ptr_d  = wrap_inc(out_src_q);
                end
                hold_cnt_d = HOLD_INIT;
                state_d    = (HOLDOFF == 0) ? IDLE : HOLD;
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating count of audio payloads overwritten before being issued.
    always_comb begin
        drops_d = drops_q;
        for (int i = 0; i < NUM_SESS; i++) begin
            if (aud_ovf[i] && (drops_d != {DROP_W{1'b1}})) begin
                drops_d = drops_d + DROP_W'(1);
            end
        end
    end

    // FSM, registered outputs, pointers and drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            out_cmd_q  <= CMD_NONE;
            out_data_q <= '0;
            out_src_q  <= '0;
            gnt_mask_q <= '0;
            ctrl_ptr_q <= '0;
            aud_ptr_q  <= '0;
            hold_cnt_q <= '0;
            drops_q    <= '0;
        end else begin
            state_q    <= state_d;
            out_cmd_q  <= out_cmd_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            gnt_mask_q <= gnt_mask_d;
            ctrl_ptr_q <= ctrl_ptr_d;
            aud_ptr_q  <= aud_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            drops_q    <= drops_d;
        end
    end

    // Slot full flags: a write sets, a grant clears, a write in the clear cycle wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_full_q <= '0;
            aud_full_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_SESS; i++) begin
                if (ctrl_accept[i]) begin
                    ctrl_full_q[i] <= 1'b1;
                end else if (ctrl_clr[i]) begin
                    ctrl_full_q[i] <= 1'b0;
                end
                if (aud_wr[i]) begin
                    aud_full_q[i] <= 1'b1;
                end else if (aud_clr[i]) begin
                    aud_full_q[i] <= 1'b0;
                end
            end
        end
    end

    // Slot payload storage; only meaningful while the matching full flag is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SESS; i++) begin
            if (ctrl_accept[i]) begin
                ctrl_data_q[i] <= in_data[DATA_W*i +: DATA_W];
            end
            if (aud_wr[i]) begin
                aud_data_q[i] <= in_data[DATA_W*i +: DATA_W];
            end
        end
    end

    assign out_cmd     = out_cmd_q;
    assign out_data    = out_data_q;
    assign out_src     = out_src_q;
    assign sess_busy   = ctrl_full_q;
    assign audio_drops = drops_q;

endmodule

// File: tb/tb_transport_arbiter.sv
// Bench for transport_arbiter (4 sessions, 16-bit data, 2-bit drop counter,
// HOLDOFF 1). Expected packets go into a queue when stimulus is driven; a
// negedge monitor pops and compares each issued packet.
module tb_transport_arbiter;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [15:0] data;
        logic [1:0]  src;
        logic [15:0] mask;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [7:0]  in_cmd;
    logic [63:0] in_data;
    logic        transport_busy;
    logic [1:0]  out_cmd;
    logic [15:0] out_data;
    logic [1:0]  out_src;
    logic [3:0]  sess_busy;
    logic [1:0]  audio_drops;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    transport_arbiter #(
        .NUM_SESS (4),
        .DATA_W   (16),
        .DROP_W   (2),
        .HOLDOFF  (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_cmd         (in_cmd),
        .in_data        (in_data),
        .transport_busy (transport_busy),
        .out_cmd        (out_cmd),
        .out_data       (out_data),
        .out_src        (out_src),
        .sess_busy      (sess_busy),
        .audio_drops    (audio_drops)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Scoreboard monitor: every issued packet must match the queue head.
    always @(negedge clk) begin
        if (reset && out_cmd != 2'b00) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_packet: got cmd=%b data=%h src=%0d, required no packet",
                         out_cmd, out_data, out_src);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_cmd !== e.cmd || out_src !== e.src ||
                    (out_data & e.mask) !== (e.data & e.mask)) begin
                    fails++;
                    $display("FAIL packet: got cmd=%b data=%h src=%0d, required cmd=%b data=%h (mask %h) src=%0d",
                             out_cmd, out_data, out_src, e.cmd, e.data, e.mask, e.src);
                end else begin
                    $display("packet cmd=%b data=%h src=%0d ok", out_cmd, out_data, out_src);
                end
            end
        end
    end

    task automatic push_exp(input logic [1:0] c, input logic [15:0] d,
                            input logic [1:0] s, input logic [15:0] m);
        exp_t e;
        e.cmd = c; e.data = d; e.src = s; e.mask = m;
        sb.push_back(e);
    endtask

    task automatic set_in(input int s, input logic [1:0] c, input logic [15:0] d);
        in_cmd[2*s +: 2]   = c;
        in_data[16*s +: 16] = d;
    endtask

    task automatic clear_in();
        in_cmd  = '0;
        in_data = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d packets outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (out_cmd !== 2'b00 || out_data !== 16'h0 || out_src !== 2'd0 ||
            sess_busy !== 4'h0 || audio_drops !== 2'd0) begin
            fails++;
            $display("FAIL %s: got cmd=%b data=%h src=%0d busy=%b drops=%0d, required all 0",
                     name, out_cmd, out_data, out_src, sess_busy, audio_drops);
        end
    endtask

    task automatic test_reset();
        #12;
        check_all_zero("reset_asserted");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset_released");
        $display("test_reset done");
    endtask

    task automatic test_single_ctrl();
        @(negedge clk);
        set_in(0, 2'b01, 16'h0701);
        push_exp(2'b01, 16'h0701, 2'd0, 16'hFFFF);
        @(negedge clk);
        clear_in();
        checks++;
        if (sess_busy[0] !== 1'b1 || out_cmd !== 2'b00) begin
            fails++;
            $display("FAIL single_pending: got busy0=%b cmd=%b, required busy0=1 cmd=00", sess_busy[0], out_cmd);
        end
        @(negedge clk);
        checks++;
        if (out_cmd !== 2'b01 || out_src !== 2'd0) begin
            fails++;
            $display("FAIL single_issue_time: got cmd=%b src=%0d, required cmd=01 src=0", out_cmd, out_src);
        end
        @(negedge clk);
        checks++;
        if (out_cmd !== 2'b00 || sess_busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL single_after: got cmd=%b busy0=%b, required cmd=00 busy0=0", out_cmd, sess_busy[0]);
        end
        wait_drain(20);
        $display("test_single_ctrl done");
    endtask

    task automatic test_priority();
        @(negedge clk);
        set_in(1, 2'b10, 16'hAAAA);
        set_in(2, 2'b01, 16'h0302);
        push_exp(2'b01, 16'h0302, 2'd2, 16'hFFFF);
        push_exp(2'b10, 16'hAAAA, 2'd1, 16'hFFFF);
        @(negedge clk);
        clear_in();
        @(negedge clk);
        checks++;
        if (out_cmd !== 2'b01 || out_src !== 2'd2) begin
            fails++;
            $display("FAIL prio_ctrl_first: got cmd=%b src=%0d, required cmd=01 src=2", out_cmd, out_src);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (out_cmd !== 2'b00) begin
            fails++;
            $display("FAIL prio_gap: got cmd=%b, required 00", out_cmd);
        end
        @(negedge clk);
        checks++;
        if (out_cmd !== 2'b10 || out_src !== 2'd1) begin
            fails++;
            $display("FAIL prio_audio_second: got cmd=%b src=%0d, required cmd=10 src=1", out_cmd, out_src);
        end
        wait_drain(20);
        $display("test_priority done");
    endtask

    task automatic test_reset_mid_send();
        bit seen;
        @(negedge clk);
        set_in(0, 2'b01, 16'h5555);
        push_exp(2'b01, 16'h5555, 2'd0, 16'hFFFF);
        @(negedge clk);
        clear_in();
        @(negedge clk);
        checks++;
        if (out_cmd !== 2'b01) begin
            fails++;
            $display("FAIL midsend_issuing: got cmd=%b, required 01", out_cmd);
        end
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midsend_reset_immediate");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_cmd !== 2'b00) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            fails++;
            $display("FAIL midsend_reissue: got a packet after reset release, required none");
        end
        sb.delete();
        $display("test_reset_mid_send done");
    endtask

    // Backpressure plus audio-drop saturation while nothing can be issued.
    task automatic test_backpressure();
        logic [1:0] exp_drops;
        @(negedge clk);
        transport_busy = 1'b1;
        set_in(3, 2'b01, 16'h0C03);
        set_in(0, 2'b10, 16'hA000);
        push_exp(2'b01, 16'h0C03, 2'd3, 16'hFFFF);
        push_exp(2'b10, 16'hA004, 2'd0, 16'hFFFF);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (out_cmd !== 2'b00) begin
                fails++;
                $display("FAIL bp_hold_%0d: got cmd=%b, required 00", k, out_cmd);
            end
            if (k < 5) begin
                exp_drops = (k > 3) ? 2'd3 : 2'(k);
                checks++;
                if (audio_drops !== exp_drops) begin
                    fails++;
                    $display("FAIL drops_%0d: got %0d, required %0d", k, audio_drops, exp_drops);
                end
            end
            if (k == 5) begin
                checks++;
                if (sess_busy[3] !== 1'b1) begin
                    fails++;
                    $display("FAIL bp_sess_busy3: got %b, required 1", sess_busy[3]);
                end
            end
            clear_in();
            if (k < 4) set_in(0, 2'b10, 16'hA000 + 16'(k + 1));
        end
        transport_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (out_cmd !== 2'b01 || out_src !== 2'd3) begin
            fails++;
            $display("FAIL bp_release: got cmd=%b src=%0d, required cmd=01 src=3", out_cmd, out_src);
        end
        wait_drain(20);
        $display("test_backpressure done");
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            push_exp(2'b10, {8'(i % 4), 8'h00}, 2'(i % 4), 16'hFF00);
        end
        for (int k = 0; k < 21; k++) begin
            for (int s = 0; s < 4; s++) set_in(s, 2'b10, {8'(s), 8'(k)});
            @(negedge clk);
            if (k == 3) begin
                checks++;
                if (audio_drops === 2'd0) begin
                    fails++;
                    $display("FAIL rr_drops_nonzero: got %0d, required >0", audio_drops);
                end
            end
        end
        clear_in();
        wait_drain(80);
        checks++;
        if (audio_drops !== 2'd3) begin
            fails++;
            $display("FAIL rr_drops_saturate: got %0d, required 3", audio_drops);
        end
        $display("test_round_robin done");
    endtask

    task automatic test_ctrl_full();
        @(negedge clk);
        transport_busy = 1'b1;
        set_in(1, 2'b01, 16'h1111);
        push_exp(2'b01, 16'h1111, 2'd1, 16'hFFFF);
        @(negedge clk);
        set_in(1, 2'b01, 16'h2222);
        checks++;
        if (sess_busy[1] !== 1'b1) begin
            fails++;
            $display("FAIL ctrlfull_busy: got %b, required 1", sess_busy[1]);
        end
        @(negedge clk);
        clear_in();
        @(negedge clk);
        transport_busy = 1'b0;
        wait_drain(20);
        checks++;
        if (sess_busy[1] !== 1'b0) begin
            fails++;
            $display("FAIL ctrlfull_cleared: got %b, required 0", sess_busy[1]);
        end
        $display("test_ctrl_full done");
    endtask

    task automatic test_coincident_write();
        @(negedge clk);
        set_in(2, 2'b01, 16'h3333);
        push_exp(2'b01, 16'h3333, 2'd2, 16'hFFFF);
        push_exp(2'b01, 16'h4444, 2'd2, 16'hFFFF);
        @(negedge clk);
        clear_in();
        @(negedge clk);
        set_in(2, 2'b01, 16'h4444);
        @(negedge clk);
        clear_in();
        checks++;
        if (sess_busy[2] !== 1'b1) begin
            fails++;
            $display("FAIL coincident_kept: got busy2=%b, required 1", sess_busy[2]);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (out_cmd !== 2'b01 || out_data !== 16'h4444) begin
            fails++;
            $display("FAIL coincident_issue: got cmd=%b data=%h, required cmd=01 data=4444", out_cmd, out_data);
        end
        wait_drain(20);
        $display("test_coincident_write done");
    endtask

    initial begin
        reset          = 1'b0;
        in_cmd         = '0;
        in_data        = '0;
        transport_busy = 1'b0;
        test_reset();
        test_single_ctrl();
        test_priority();
        test_reset_mid_send();
        test_backpressure();
        test_round_robin();
        test_ctrl_full();
        test_coincident_write();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
